uart_fifo: RTL

Buffered, parametrised successor of the pComputer UART. It adds TX and RX FIFOs, a runtime-programmable baud divisor, optional parity, one or two stop bits, error flags and maskable level interrupts. It sits on the pCPU MMIO bus with the same byte-lane convention as the existing UART: data is carried in d[31:24] and spo[31:24], and word addresses are multiplied by 4 in assembly.

---
 rtl/uart_fifo.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: buffered MMIO UART with TX/RX FIFOs, programmable baud divisor,
// optional parity, one/two stop bits, sticky error flags and level irq.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   a, d, we      MMIO word address, write data (byte lane d[31:24]), write strobe
//   spo           combinational read data for address a
//   irq           registered level interrupt
//   rx, tx        serial in (2-flop synchronized) / serial out (idle high)

// Byte FIFO: circular buffer, power-of-two depth, count is AW+1 bits.
// A push while full only lands if a pop frees a slot in the same cycle.
module uart_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr_ok, rd_ok;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign head  = mem[rp];

  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= din;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0; rp <= '0; count <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
endmodule

module uart_fifo #(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  input  logic        rx,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV0 = 16'(CLOCK_FREQ / (BAUD_RATE * 16) - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  // bus decode
  logic wr0, wr1, wr2, wr3, err_clr, rx_pop;
  assign wr0     = we && a == 3'd0;
  assign wr1     = we && a == 3'd1;
  assign wr2     = we && a == 3'd2;
  assign wr3     = we && a == 3'd3;
  assign err_clr = wr1 & d[25];
  assign rx_pop  = wr1 & d[24];

  logic unused;
  assign unused = ^d[23:16];

  // control / divisor / oversample tick
  logic [4:0]  ctrl;   // {tx_ie, rx_ie, two_stop, parity_odd, parity_en}
  logic [15:0] div, tcnt;
  logic        tick;
  assign tick = tcnt == div;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl <= '0; div <= DIV0; tcnt <= '0;
    end else begin
      if (wr2) ctrl <= d[28:24];
      if (wr3) div  <= d[15:0];
      tcnt <= (wr3 || tick) ? '0 : tcnt + 16'd1;
    end

  // FIFOs
  logic [7:0]  tx_head, rx_head, rsh, rsh_n;
  logic [AW:0] tx_count, rx_count;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n), .push(wr0 & ~tx_full), .pop(tx_pop), .din(d[31:24]),
    .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty));

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rsh),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty));

  // TX FSM. Frame timing is aligned to the tick grid: the head is popped on a
  // tick, so every bit (including start) lasts exactly 16 ticks.
  tx_state_t   tst, tst_n;
  logic [3:0]  tph, tph_n;
  logic [2:0]  tbit, tbit_n;
  logic [7:0]  tsh, tsh_n;
  logic        tpar, tpar_n, tpen, tpen_n, t2s, t2s_n, tsec, tsec_n, tx_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tst <= T_IDLE; tph <= '0; tbit <= '0; tsh <= '0;
      tpar <= 1'b0; tpen <= 1'b0; t2s <= 1'b0; tsec <= 1'b0; tx <= 1'b1;
    end else begin
      tst <= tst_n; tph <= tph_n; tbit <= tbit_n; tsh <= tsh_n;
      tpar <= tpar_n; tpen <= tpen_n; t2s <= t2s_n; tsec <= tsec_n; tx <= tx_n;
    end

  always_comb begin
    tst_n = tst; tph_n = tph; tbit_n = tbit; tsh_n = tsh; tpar_n = tpar;
    tpen_n = tpen; t2s_n = t2s; tsec_n = tsec; tx_pop = 1'b0; tx_n = 1'b1;
    if (tick) begin
      if (tst == T_IDLE) begin
        if (!tx_empty) begin
          // frame format is latched here so mid-frame control writes wait a frame
          tx_pop = 1'b1; tst_n = T_START; tph_n = '0; tsh_n = tx_head;
          tpar_n = ^tx_head ^ ctrl[1]; tpen_n = ctrl[0]; t2s_n = ctrl[2];
        end
      end else begin
        tph_n = tph + 4'd1;
        if (tph == 4'd15)
          case (tst)
            T_START: begin tst_n = T_DATA; tbit_n = '0; end
            T_DATA: begin
              tsh_n  = tsh >> 1;
              tbit_n = tbit + 3'd1;
              if (tbit == 3'd7) begin tst_n = tpen ? T_PAR : T_STOP; tsec_n = 1'b0; end
            end
            T_PAR:   begin tst_n = T_STOP; tsec_n = 1'b0; end
            T_STOP:  if (t2s && !tsec) tsec_n = 1'b1; else tst_n = T_IDLE;
            default: tst_n = T_IDLE;
          endcase
      end
    end
    case (tst_n)
      T_START: tx_n = 1'b0;
      T_DATA:  tx_n = tsh_n[0];
      T_PAR:   tx_n = tpar_n;
      default: tx_n = 1'b1;
    endcase
  end

  // RX: synchronizer + FSM. Phase counter keeps running across bits, so every
  // sample lands at phase 7 of its bit; state changes happen at the sample.
  logic      rx_s1, rs;
  rx_state_t rxs, rxs_n;
  logic [3:0] rph, rph_n;
  logic [2:0] rbit, rbit_n;
  logic       perr_set, ferr_set, ovr_set, ovr, perr, ferr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1 <= 1'b1; rs <= 1'b1;
      rxs <= R_IDLE; rph <= '0; rbit <= '0; rsh <= '0;
    end else begin
      rx_s1 <= rx; rs <= rx_s1;
      rxs <= rxs_n; rph <= rph_n; rbit <= rbit_n; rsh <= rsh_n;
    end

  always_comb begin
    rxs_n = rxs; rph_n = rph; rbit_n = rbit; rsh_n = rsh;
    rx_push = 1'b0; perr_set = 1'b0; ferr_set = 1'b0;
    if (tick) begin
      if (rxs == R_IDLE) begin
        if (!rs) begin rxs_n = R_START; rph_n = '0; end
      end else begin
        rph_n = rph + 4'd1;
        if (rph == 4'd7)
          case (rxs)
            R_START: if (rs) rxs_n = R_IDLE; else begin rxs_n = R_DATA; rbit_n = '0; end
            R_DATA: begin
              rsh_n  = {rs, rsh[7:1]};
              rbit_n = rbit + 3'd1;
              if (rbit == 3'd7) rxs_n = ctrl[0] ? R_PAR : R_STOP;
            end
            R_PAR:   begin perr_set = rs != (^rsh ^ ctrl[1]); rxs_n = R_STOP; end
            R_STOP:  begin rx_push = 1'b1; ferr_set = ~rs; rxs_n = R_IDLE; end
            default: rxs_n = R_IDLE;
          endcase
      end
    end
  end

  // sticky errors: set wins over a same-cycle clear
  assign ovr_set = rx_push & rx_full & ~rx_pop;

  logic tx_idle;
  assign tx_idle = tx_empty && tst == T_IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovr <= 1'b0; perr <= 1'b0; ferr <= 1'b0; irq <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~err_clr);
      perr <= perr_set | (perr & ~err_clr);
      ferr <= ferr_set | (ferr & ~err_clr);
      irq  <= (ctrl[3] & ~rx_empty) | (ctrl[4] & tx_idle);
    end

  always_comb begin
    spo = '0;
    case (a)
      3'd0: spo[31:24] = rx_empty ? 8'h00 : rx_head;
      3'd1: spo[30:24] = {ferr, perr, ovr, tx_full, tx_idle, rx_full, ~rx_empty};
      3'd2: spo[28:24] = ctrl;
      3'd3: spo[15:0]  = div;
      3'd4: begin spo[23:16] = 8'(rx_count); spo[7:0] = 8'(tx_count); end
      default: ;
    endcase
  end
endmodule
